fifo_wr_ctrl: RTL

Write-side controller for the ip_fifo test loop, running in the FIFO write clock domain. It waits for the FIFO to report empty and then waits a settle interval. It then writes a burst of incrementing data words until the FIFO fills, and hands off to the read-side controller, which drains the FIFO once it sees full. Status outputs (burst count, sticky overflow error) feed the debug/ILA path.

---
 rtl/fifo_wr_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the ip_fifo test loop.
// Waits for empty, settles, then fills the FIFO with a counting burst.
module fifo_wr_ctrl #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] START_VAL = '0,
  parameter int                WAIT_CYC  = 10,
  parameter int                CNT_W     = 16
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              wr_rst_busy,
  input  logic              empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic              overflow_err
);

  localparam int WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e             st_q;
  logic               e1_q;
  logic               e2_q;
  logic               wr_en_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  data_d;
  logic [CNT_W-1:0]   burst_q;
  logic               ovf_q;
  logic [WCW-1:0]     wcnt_q;

  assign data_d = data_q + 1'b1;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ARM;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      wr_en_q <= 1'b0;
      data_q  <= START_VAL;
      burst_q <= '0;
      ovf_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      e1_q <= empty;
      e2_q <= e1_q;
      if (wr_en_q && full)
        ovf_q <= 1'b1;
      if (wr_rst_busy) begin
        st_q    <= ARM;
        wr_en_q <= 1'b0;
        data_q  <= START_VAL;
        wcnt_q  <= '0;
      end else begin
        unique case (st_q)
          // ARM waits for a fresh non-empty so a stale flag cannot retrigger
          ARM: begin
            if (!e2_q)
              st_q <= IDLE;
          end
          IDLE: begin
            data_q <= START_VAL;
            wcnt_q <= '0;
            if (e2_q)
              st_q <= WAIT;
          end
          WAIT: begin
            if (wcnt_q == WLAST) begin
              st_q    <= WRITE;
              wr_en_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
          WRITE: begin
            data_q <= data_d;
            if (almost_full || full) begin
              wr_en_q <= 1'b0;
              burst_q <= burst_q + 1'b1;
              st_q    <= ARM;
            end
          end
        endcase
      end
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = data_q;
  assign burst_cnt    = burst_q;
  assign overflow_err = ovf_q;

endmodule
